// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding the IF/ID register.
// Holds the PC, keeps at most one instruction-memory request in flight using a req/ready
// handshake with an rvalid response, and buffers the returned word until the decode stage
// takes it. A NOP bubble is driven whenever no fetched instruction is held.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   StallF                        hazard unit: hold the current fetch output
//   PCSrcE, PCTargetE             EX redirect strobe and target (bits [1:0] forced to 0)
//   imem_req, imem_addr           request valid / word address (always the PC)
//   imem_ready                    request accepted when imem_req & imem_ready at an edge
//   imem_rvalid, imem_rdata       single-cycle response pulse and data
//   RD, PCF, PCPlus4F             instruction, its PC and PC+4 towards IF/ID
//   InstrValidF                   RD holds a real fetched instruction
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        StallF,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] RD,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F,
   output logic        InstrValidF
);

   typedef enum logic [1:0] {
      StReq,
      StWait,
      StValid
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic        discard_q, discard_d;
   logic [31:0] redirect_pc;
   logic        unused_tgt_lsbs;

   assign redirect_pc     = {PCTargetE[31:2], 2'b00};
   assign unused_tgt_lsbs = ^PCTargetE[1:0];

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      buf_d     = buf_q;
      discard_d = discard_q;
      unique case (state_q)
         StReq: begin
            // imem_req is high here whenever a clock edge can occur
            if (imem_ready) begin
               state_d   = StWait;
               discard_d = PCSrcE;
            end
         end
         StWait: begin
            if (imem_rvalid) begin
               discard_d = 1'b0;
               // A redirect on the same edge as the response also invalidates it
               if (discard_q || PCSrcE) begin
                  state_d = StReq;
               end else begin
                  buf_d   = imem_rdata;
                  state_d = StValid;
               end
            end else if (PCSrcE) begin
               discard_d = 1'b1;
            end
         end
         StValid: begin
            if (PCSrcE) begin
               state_d = StReq;
            end else if (!StallF) begin
               state_d = StReq;
               pc_d    = pc_q + 32'd4;
            end
         end
         default: state_d = StReq;
      endcase
      // Redirect wins over stall and sequential advance in every state
      if (PCSrcE) begin
         pc_d = redirect_pc;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StReq;
         pc_q      <= RESET_PC;
         buf_q     <= NOP_INSTR;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         buf_q     <= buf_d;
         discard_q <= discard_d;
      end
   end

   // Request is suppressed while reset is held so nothing is issued from a half-reset PC
   assign imem_req    = (state_q == StReq) && reset_n;
   assign imem_addr   = pc_q;
   assign InstrValidF = (state_q == StValid);
   assign RD          = InstrValidF ? buf_q : NOP_INSTR;
   assign PCF         = pc_q;
   assign PCPlus4F    = pc_q + 32'd4;

endmodule
